// File: rtl/id_ex_stage.sv
// id_ex_stage: ID->EX pipeline register with operand forwarding and hazard stall.
// Latency: 1 cycle from ID inputs to EX outputs; o_stall_id is combinational.
// Backpressure: i_hold freezes the stage, i_flush kills it; optional macro OPERAND_FWD_EN enables EX/MEM forwarding.
module id_ex_stage #(
  parameter int          CTRL_W   = 12,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_id_valid,
  input  logic [31:0]       i_id_pc,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic              i_id_uses_rs,
  input  logic              i_id_uses_rt,
  input  logic [4:0]        i_id_waddr,
  input  logic              i_id_regwrite,
  input  logic              i_id_memread,
  input  logic [31:0]       i_id_imm,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic [31:0]       i_rf_rdata1,
  input  logic [31:0]       i_rf_rdata2,
  input  logic [31:0]       i_ex_result,
  input  logic              i_mem_regwrite,
  input  logic [4:0]        i_mem_waddr,
  input  logic [31:0]       i_mem_wdata,
  input  logic              i_wb_we,
  input  logic [4:0]        i_wb_waddr,
  input  logic [31:0]       i_wb_wdata,
  output logic              o_ex_valid,
  output logic [31:0]       o_ex_pc,
  output logic [31:0]       o_ex_opa,
  output logic [31:0]       o_ex_opb,
  output logic [31:0]       o_ex_imm,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic [4:0]        o_ex_waddr,
  output logic              o_ex_regwrite,
  output logic              o_ex_memread,
  output logic              o_stall_id
);

  logic              valid_q, regwrite_q, memread_q;
  logic [31:0]       pc_q, opa_q, opb_q, imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [4:0]        waddr_q;
  logic [31:0]       opa_d, opb_d;
  logic              lu;

  // Source-register matches against the instruction currently in EX
  logic rs_hit_ex, rt_hit_ex;
  assign rs_hit_ex = i_id_uses_rs && (i_id_rs == waddr_q);
  assign rt_hit_ex = i_id_uses_rt && (i_id_rt == waddr_q);

`ifdef OPERAND_FWD_EN
  // EX results are forwardable only for non-load writers; loads are caught by lu
  logic ex_fwd_ok;
  assign ex_fwd_ok = valid_q && regwrite_q && !memread_q;

  // Load-use: the loaded value exists only from MEM onwards, so bubble once
  always_comb begin
    lu = i_id_valid && valid_q && memread_q && (waddr_q != 5'd0) && (rs_hit_ex || rt_hit_ex);
  end
`else
  // Without forwarding, any pending writer in EX or MEM blocks until it reaches WB
  logic rs_hit_mem, rt_hit_mem, ex_haz, mem_haz;
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{i_ex_result, i_mem_wdata};
  assign rs_hit_mem = i_id_uses_rs && (i_id_rs == i_mem_waddr);
  assign rt_hit_mem = i_id_uses_rt && (i_id_rt == i_mem_waddr);
  assign ex_haz  = valid_q && regwrite_q && (waddr_q != 5'd0) && (rs_hit_ex || rt_hit_ex);
  assign mem_haz = i_mem_regwrite && (i_mem_waddr != 5'd0) && (rs_hit_mem || rt_hit_mem);

  // General RAW hazard: bubble while the writer is in EX or MEM
  always_comb begin
    lu = i_id_valid && (ex_haz || mem_haz);
  end
`endif

  // Resolve rs operand: r0, then EX, MEM, WB write-through, then register file
  always_comb begin
    opa_d = i_rf_rdata1;
    if (i_id_rs == 5'd0)
      opa_d = 32'd0;
`ifdef OPERAND_FWD_EN
    else if (ex_fwd_ok && (waddr_q == i_id_rs))
      opa_d = i_ex_result;
    else if (i_mem_regwrite && (i_mem_waddr == i_id_rs))
      opa_d = i_mem_wdata;
`endif
    else if (i_wb_we && (i_wb_waddr == i_id_rs))
      opa_d = i_wb_wdata;
  end

  // Resolve rt operand with the same priority as rs
  always_comb begin
    opb_d = i_rf_rdata2;
    if (i_id_rt == 5'd0)
      opb_d = 32'd0;
`ifdef OPERAND_FWD_EN
    else if (ex_fwd_ok && (waddr_q == i_id_rt))
      opb_d = i_ex_result;
    else if (i_mem_regwrite && (i_mem_waddr == i_id_rt))
      opb_d = i_mem_wdata;
`endif
    else if (i_wb_we && (i_wb_waddr == i_id_rt))
      opb_d = i_wb_wdata;
  end

  // A flush redirects fetch, so holding IF/ID would be pointless
  assign o_stall_id = (i_hold || lu) && !i_flush;

  // Pipeline register: flush beats hold, hold beats bubble, bubble beats load
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      pc_q       <= RESET_PC;
      opa_q      <= 32'd0;
      opb_q      <= 32'd0;
      imm_q      <= 32'd0;
      ctrl_q     <= '0;
      waddr_q    <= 5'd0;
    end else if (i_flush || (!i_hold && lu)) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else if (!i_hold) begin
      valid_q    <= i_id_valid;
      regwrite_q <= i_id_valid && i_id_regwrite && (i_id_waddr != 5'd0);
      memread_q  <= i_id_valid && i_id_memread;
      pc_q       <= i_id_pc;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      imm_q      <= i_id_imm;
      ctrl_q     <= i_id_ctrl;
      waddr_q    <= i_id_waddr;
    end
  end

  assign o_ex_valid    = valid_q;
  assign o_ex_pc       = pc_q;
  assign o_ex_opa      = opa_q;
  assign o_ex_opb      = opb_q;
  assign o_ex_imm      = imm_q;
  assign o_ex_ctrl     = ctrl_q;
  assign o_ex_waddr    = waddr_q;
  assign o_ex_regwrite = regwrite_q;
  assign o_ex_memread  = memread_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the conveyor (pipelined) MIPS core.
- Sits directly downstream of the register file.
- Captures the two read-port values together with the decoded instruction fields.
- Resolves data hazards by operand forwarding, plus a one-bubble stall for load-use.
- Drives the EX stage, and drives the stall signal back to IF/ID.

Parameters:
CTRL_W, 12, width of the opaque decoded control bundle passed to EX (ALU op, src select, etc.)
RESET_PC, 32'h0000_0000, value held on o_ex_pc while the stage is invalid/reset

Ports:
i_clk  input  1  clock; all state updates on posedge
i_rst  input  1  asynchronous, active-high reset
i_hold  input  1  downstream stall; freeze this stage
i_flush  input  1  kill the instruction entering EX (branch/jump taken)
i_id_valid  input  1  ID holds a real instruction
i_id_pc  input  32  PC of the ID instruction
i_id_rs, i_id_rt  input  5  source register numbers (also register-file read addresses)
i_id_uses_rs, i_id_uses_rt  input  1  instruction actually reads rs / rt
i_id_waddr  input  5  destination register
i_id_regwrite, i_id_memread  input  1  writes a register / is a load
i_id_imm  input  32  sign/zero-extended immediate
i_id_ctrl  input  CTRL_W  control bundle
i_rf_rdata1, i_rf_rdata2  input  32  register-file read data for rs / rt
i_ex_result  input  32  combinational ALU result of the instruction currently in EX
i_mem_regwrite  input  1  MEM-stage instruction writes a register
i_mem_waddr  input  5  MEM-stage destination register
i_mem_wdata  input  32  MEM-stage result
i_wb_we  input  1  WB write enable (same signal as register-file write enable)
i_wb_waddr  input  5  WB destination register
i_wb_wdata  input  32  WB write data
o_ex_valid  output  1  EX holds a real instruction
o_ex_pc  output  32  PC of the EX instruction
o_ex_opa, o_ex_opb  output  32  resolved rs / rt operands
o_ex_imm  output  32  immediate
o_ex_ctrl  output  CTRL_W  control bundle
o_ex_waddr  output  5  destination register
o_ex_regwrite, o_ex_memread  output  1  qualified with o_ex_valid
o_stall_id  output  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset (asynchronous, immediate, mid-operation included): all registered outputs are 0, except o_ex_pc = RESET_PC.
- Latency: 1 cycle from ID to the EX outputs.
- Operand resolution, performed independently for rs and rt (combinational, then registered). Sources in priority order:
  1. Register 0 → always 0; never forwarded.
  2. EX source: o_ex_valid & o_ex_regwrite & !o_ex_memread & o_ex_waddr == reg → i_ex_result.
  3. MEM source: i_mem_regwrite & i_mem_waddr == reg → i_mem_wdata.
  4. WB source: i_wb_we & i_wb_waddr == reg → i_wb_wdata. This write-through is needed because the register file updates only at posedge, so its read data is stale in the write cycle.
  5. Otherwise → i_rf_rdata1 / i_rf_rdata2.
- Load-use hazard (lu):
  - Condition: i_id_valid & o_ex_valid & o_ex_memread & o_ex_waddr != 0 & ((i_id_uses_rs & i_id_rs == o_ex_waddr) | (i_id_uses_rt & i_id_rt == o_ex_waddr)).
  - Response: insert one bubble; the instruction is accepted on the following cycle via MEM forwarding.
- o_stall_id = (i_hold | lu) & !i_flush.
- Register update priority at posedge:
  1. i_flush: o_ex_valid, o_ex_regwrite, o_ex_memread ← 0; other fields don't-care. Flush wins over i_hold.
  2. i_hold: all outputs keep their values.
  3. lu: bubble; o_ex_valid / o_ex_regwrite / o_ex_memread ← 0.
  4. Otherwise: load all fields from ID. o_ex_valid ← i_id_valid; regwrite/memread are ANDed with i_id_valid.
- No write to register 0 is ever advertised: o_ex_regwrite ← 0 when i_id_waddr == 0.
- Simultaneous cases:
  - lu and a matching WB write → the stall still occurs.
  - EX and MEM both match → the EX source wins.

Optional Feature:
- Macro: OPERAND_FWD_EN.
- Defined: EX and MEM forwarding operate as described in Behaviour.
- Undefined:
  - EX and MEM forwarding are removed; WB write-through and register-0 handling remain.
  - lu is widened to a general hazard: any EX writer, or MEM writer (i_mem_regwrite), whose nonzero destination matches a used source.
  - Each such hazard inserts bubbles until the writer reaches WB.

Test Plan:
- Reset mid-stream: assert i_rst while o_ex_valid=1 → all outputs 0 and o_ex_pc=RESET_PC immediately, without waiting for a clock edge.
- EX forward: addi r5 in EX (i_ex_result=0x1234), then add r6,r5,r5 in ID → o_ex_opa = o_ex_opb = 0x1234, no stall.
- EX/MEM priority: EX writes r7=0xAAAA while MEM writes r7=0xBBBB → operand = 0xAAAA.
  - Second check: WB writes r3=0x55 with i_rf_rdata1 stale=0 → operand = 0x55.
- Load-use: lw r8 in EX, then sub r9,r8,r1 in ID → o_stall_id=1 for 1 cycle and bubble (o_ex_valid=0).
  - Next cycle: i_mem_wdata=0xCAFE → o_ex_opa=0xCAFE.
- Flush during hold: i_flush=1 and i_hold=1 together → o_ex_valid=0 next cycle, o_stall_id=0.
- Register 0: rs=0 while MEM writes r0=0xFFFF → o_ex_opa=0.
  - Without OPERAND_FWD_EN: an EX writer matching a used source → 2 bubbles before issue.
